mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL provide parameter: TIMEOUT, default 8, stall cycles before abort (legal 1..15).
REQ-002 SHALL provide port: clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: req  input  16  per-requester request, bit i = requester i.
REQ-005 SHALL provide port: in  input  16  16 data lines feeding the 16:1 select path.
REQ-006 SHALL provide port: out_ready  input  1  downstream accepts out this cycle.
REQ-007 SHALL provide port: sel  output  4  registered select index of current grant.
REQ-008 SHALL provide port: gnt  output  16  registered one-hot grant, all-zero when idle.
REQ-009 SHALL provide port: out  output  1  selected data bit, in[sel] while out_valid, else 0.
REQ-010 SHALL provide port: out_valid  output  1  registered, out carries a grant's data.
REQ-011 SHALL provide port: err  output  1  registered one-cycle pulse on timeout abort.
REQ-012 SHALL provide port: xfer_cnt  output  8  registered count of completed transfers.

Function
REQ-013 SHALL implement two states: IDLE and SEND.
REQ-014 IDLE with req != 0 SHALL pick the first set req bit searching from last+1 upward, wrapping 15->0, and go to SEND next edge.
REQ-015 IDLE with req == 0 SHALL remain in IDLE; sel holds its value, gnt = 0, out_valid = 0.
REQ-016 On entry to SEND, sel = picked index, gnt = 1<<sel, out_valid = 1, same edge; latency req->out_valid is one cycle.
REQ-017 out SHALL be combinational from registered sel: out = in[sel] & out_valid; in may change while in SEND and out follows it.
REQ-018 Transfer SHALL occur on any edge where out_valid and out_ready are both 1; then last = sel, xfer_cnt += 1, state = IDLE, gnt = 0, out_valid = 0.
REQ-019 xfer_cnt SHALL wrap 255->0.
REQ-020 One grant per transfer; the IDLE bubble is mandatory (max throughput one transfer per two cycles).
REQ-021 In SEND, if req[sel] = 0 and no transfer this edge, the grant SHALL be withdrawn: IDLE, no count, no err, last unchanged.
REQ-022 Transfer and req[sel] withdrawal on the same edge SHALL count as a transfer.
REQ-023 A 4-bit stall counter SHALL clear on SEND entry and increment each SEND cycle with out_ready = 0.
REQ-024 When the stall counter reaches TIMEOUT with no transfer, the edge SHALL abort: IDLE, err = 1 for one cycle, last = sel (aborted requester loses priority), no count.
REQ-025 Transfer on the same edge the stall counter would reach TIMEOUT SHALL win; no err.
REQ-026 Changes on req bits other than req[sel] during SEND SHALL not affect the current grant.
REQ-027 Only one requester SHALL be granted; gnt SHALL be zero or one-hot at all times.

Reset
REQ-028 rst_n = 0 SHALL immediately force IDLE, sel = 0, gnt = 0, out_valid = 0, out = 0, err = 0, xfer_cnt = 0, stall counter = 0, last = 15.
REQ-029 Reset mid-SEND SHALL drop the grant with no transfer counted; after release, the first search starts at index 0.
REQ-030 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset release, req = 16'h0001, in = 16'h0001, out_ready = 1 -> cycle 1: sel = 0, gnt = 16'h0001, out_valid = 1, out = 1; cycle 2: out_valid = 0, xfer_cnt = 1.
REQ-032 req = 16'hFFFF held, out_ready = 1 -> grants in order 0,1,2..15,0 on every other cycle; xfer_cnt = 16 after 32 cycles.
REQ-033 req = 16'h8001 held after grant to 0 -> next grant 15, then 0 (wrap fairness).
REQ-034 TIMEOUT = 8, req = 16'h0010, out_ready = 0 -> out_valid high 8 cycles, then err pulse 1 cycle, xfer_cnt unchanged, re-grant to 4 after one IDLE cycle.
REQ-035 In SEND on sel = 3, deassert req[3] with out_ready = 0 -> next cycle IDLE, err = 0, xfer_cnt unchanged; repeat with out_ready = 1 on the same edge -> xfer_cnt increments.
REQ-036 Assert rst_n = 0 asynchronously mid-SEND -> gnt, out_valid, xfer_cnt are 0 before the next clk edge.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: 16-requester round-robin arbiter driving a 16:1 bit mux.
// A grant is held in SEND until the consumer takes the bit (out_ready). The
// grant is also dropped if the requester withdraws its request, or if the
// consumer stalls for TIMEOUT cycles (an abort, which raises err).
// Exactly one grant is issued per transfer. A one-cycle IDLE bubble always
// separates two grants.

module mux16_rr_sched #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] in,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        out,
  output logic        out_valid,
  output logic        err,
  output logic [7:0]  xfer_cnt
);

  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  sel_r;
  logic [15:0] gnt_r;
  logic        out_valid_r;
  logic        err_r;
  logic [7:0]  xfer_cnt_r;
  logic [3:0]  stall_r;
  logic [3:0]  last_r;

  logic [3:0]  pick_s;
  logic        any_req_s;
  logic        xfer_s;
  logic        withdraw_s;
  logic [3:0]  stall_inc_s;
  logic        timeout_s;
  logic        out_s;

  // Round-robin search: first set request strictly after 'l', wrapping 15->0.
  // The final probe (k = 16) lands on 'l' itself, so a lone requester can be
  // re-granted after its own turn.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] l);
    logic [3:0] idx;
    logic [3:0] pick;
    logic       hit;
    pick = 4'd0;
    hit  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = l + k[3:0];
      if (!hit && r[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  // One-hot decode of a select index into a grant vector.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // Next-grant search and SEND-state exit conditions.
  always_comb begin
    any_req_s   = (req != 16'd0);
    pick_s      = rr_pick(req, last_r);
    xfer_s      = out_valid_r & out_ready;
    withdraw_s  = ~req[sel_r];
    stall_inc_s = stall_r + 4'd1;
    timeout_s   = (~out_ready) & (stall_inc_s == TIMEOUT_L);
    out_s       = in[sel_r] & out_valid_r;
  end

  // Arbitration FSM: all grant, status and counter state is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sel_r       <= 4'd0;
      gnt_r       <= 16'd0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
      xfer_cnt_r  <= 8'd0;
      stall_r     <= 4'd0;
      last_r      <= 4'd15;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // err is a single-cycle pulse. It is raised on the abort edge and
          // cleared on the next edge, which is this IDLE cycle.
          err_r <= 1'b0;
          if (any_req_s) begin
            state_r     <= ST_SEND;
            sel_r       <= pick_s;
            gnt_r       <= onehot16(pick_s);
            out_valid_r <= 1'b1;
            stall_r     <= 4'd0;
          end else begin
            state_r     <= ST_IDLE;
            gnt_r       <= 16'd0;
            out_valid_r <= 1'b0;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            // A transfer wins over both withdrawal and timeout on the same edge.
            state_r     <= ST_IDLE;
            gnt_r       <= 16'd0;
            out_valid_r <= 1'b0;
            last_r      <= sel_r;
            xfer_cnt_r  <= xfer_cnt_r + 8'd1;
            err_r       <= 1'b0;
          end else if (withdraw_s) begin
            // Requester gave up. Drop quietly and keep its priority position.
            state_r     <= ST_IDLE;
            gnt_r       <= 16'd0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
          end else if (timeout_s) begin
            // Consumer stalled too long. Abort and move priority past this requester.
            state_r     <= ST_IDLE;
            gnt_r       <= 16'd0;
            out_valid_r <= 1'b0;
            last_r      <= sel_r;
            err_r       <= 1'b1;
          end else begin
            state_r <= ST_SEND;
            err_r   <= 1'b0;
            if (!out_ready) begin
              stall_r <= stall_inc_s;
            end else begin
              stall_r <= stall_r;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          gnt_r       <= 16'd0;
          out_valid_r <= 1'b0;
          err_r       <= 1'b0;
          stall_r     <= 4'd0;
        end
      endcase
    end
  end

  assign sel       = sel_r;
  assign gnt       = gnt_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;
  assign xfer_cnt  = xfer_cnt_r;
  assign out       = out_s;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Testbench for mux16_rr_sched (TIMEOUT = 8).
// The testbench applies a table of single-cycle vectors through an expectation
// queue. It then runs hand-written sequences for timeout, async reset,
// round-robin order and counter wrap.

module tb_mux16_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] in;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out;
  logic        out_valid;
  logic        err;
  logic [7:0]  xfer_cnt;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0] req;
    logic [15:0] din;
    logic        rdy;
    logic [3:0]  esel;
    logic [15:0] egnt;
    logic        eov;
    logic        eout;
    logic        eerr;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t       vecs [14];
  vec_t       sb_q [$];
  logic [3:0] idx_q [$];

  mux16_rr_sched #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .err       (err),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] es, input logic [15:0] eg,
                       input logic eov, input logic eo, input logic ee, input logic [7:0] ec);
    n_vec++;
    if (sel !== es || gnt !== eg || out_valid !== eov || out !== eo || err !== ee || xfer_cnt !== ec) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d gnt=%h ov=%b out=%b err=%b cnt=%0d, expected sel=%0d gnt=%h ov=%b out=%b err=%b cnt=%0d",
               name, sel, gnt, out_valid, out, err, xfer_cnt, es, eg, eov, eo, ee, ec);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] es;
    n_vec = 0;
    n_bad = 0;

    //            req       in        rdy   sel    gnt       ov    out   err   cnt
    vecs[0]  = '{16'h0001, 16'h0001, 1'b1, 4'd0,  16'h0001, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{16'h0001, 16'h0001, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{16'h8001, 16'h0000, 1'b0, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[3]  = '{16'h8001, 16'h8000, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[4]  = '{16'h8001, 16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[5]  = '{16'h8001, 16'h0000, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[7]  = '{16'h0008, 16'h0008, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b1, 1'b0, 8'd3};
    vecs[8]  = '{16'h0000, 16'h0008, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd3};
    vecs[9]  = '{16'h0008, 16'h0000, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[10] = '{16'h0000, 16'h0000, 1'b1, 4'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd4};
    vecs[11] = '{16'h0018, 16'hFFFF, 1'b0, 4'd4,  16'h0010, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[12] = '{16'h0118, 16'hFFFF, 1'b0, 4'd4,  16'h0010, 1'b1, 1'b1, 1'b0, 8'd4};
    vecs[13] = '{16'hFFF0, 16'h0000, 1'b1, 4'd4,  16'h0000, 1'b0, 1'b0, 1'b0, 8'd5};

    // Reset state, held across a clock edge.
    rst_n     = 1'b0;
    req       = 16'h0000;
    in        = 16'h0000;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Table vectors: queue each expectation as it is driven, compare after the edge.
    for (int i = 0; i < 14; i++) begin
      req       = vecs[i].req;
      in        = vecs[i].din;
      out_ready = vecs[i].rdy;
      sb_q.push_back(vecs[i]);
      @(posedge clk); #1;
      v = sb_q.pop_front();
      check($sformatf("vec%0d", i), v.esel, v.egnt, v.eov, v.eout, v.eerr, v.ecnt);
    end

    // Stall timeout: 8 cycles valid, then abort with an err pulse, then re-grant.
    req       = 16'h0010;
    in        = 16'h0000;
    out_ready = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      check($sformatf("to_hold%0d", e), 4'd4, 16'h0010, 1'b1, 1'b0, 1'b0, 8'd5);
      if (e == 3) begin
        in = 16'h0010;
        #1 check_bit("out_follow_hi", out, 1'b1);
        in = 16'hFFEF;
        #1 check_bit("out_follow_lo", out, 1'b0);
        in = 16'h0000;
      end
    end
    @(posedge clk); #1;
    check("to_abort", 4'd4, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd5);
    @(posedge clk); #1;
    check("to_regrant", 4'd4, 16'h0010, 1'b1, 1'b0, 1'b0, 8'd5);
    req = 16'h0000;
    @(posedge clk); #1;
    check("to_withdraw", 4'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd5);

    // Asynchronous reset in the middle of a SEND.
    req = 16'h0004;
    @(posedge clk); #1;
    check("pre_reset", 4'd2, 16'h0004, 1'b1, 1'b0, 1'b0, 8'd5);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req       = 16'hFFFF;
    in        = 16'hFFFF;
    out_ready = 1'b1;

    // Full request load: expected grant order is queued, popped on each valid.
    for (int i = 0; i < 16; i++) idx_q.push_back(i[3:0]);
    idx_q.push_back(4'd0);
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk); #1;
      check_bit($sformatf("rr_valid_e%0d", e), out_valid, (e % 2 == 1) ? 1'b1 : 1'b0);
      if (out_valid === 1'b1) begin
        n_vec++;
        if (idx_q.size() == 0) begin
          n_bad++;
          $display("FAIL rr_order: got grant sel=%0d, expected no further grant", sel);
        end else begin
          es = idx_q.pop_front();
          if (sel !== es || gnt !== (16'd1 << es) || out !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_order: got sel=%0d gnt=%h out=%b, expected sel=%0d gnt=%h out=1",
                     sel, gnt, out, es, 16'd1 << es);
          end
        end
      end
      if (e == 32) begin
        n_vec++;
        if (xfer_cnt !== 8'd16) begin
          n_bad++;
          $display("FAIL rr_count: got %0d, expected 16", xfer_cnt);
        end
      end
    end
    n_vec++;
    if (idx_q.size() != 0) begin
      n_bad++;
      $display("FAIL rr_drain: got %0d grants outstanding, expected 0", idx_q.size());
    end

    // Keep transferring until xfer_cnt wraps 255 -> 0.
    for (int e = 34; e <= 512; e++) begin
      @(posedge clk); #1;
      if (e == 511) check("wrap_255", sel, gnt, 1'b1, 1'b1, 1'b0, 8'd255);
      if (e == 512) check("wrap_0", sel, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
